td4_sequencer: RTL and testbench
================================

# td4_sequencer

Multi-cycle fetch/decode/execute control unit for the TD4 CPU: the writer side of the `register` block. Each instruction, it fetches a byte from a synchronous program ROM at the current `ADDRESS`, decodes it, and drives `LOAD`/`IN_DATA` into `register`, first for the destination write and then for the PC update. It also owns the carry flag and the run/idle control.

## Interface
- No parameters. Widths are fixed by the TD4 architecture: 4-bit data, 4-bit address, 8-bit instruction.
- `CLK` in 1: system clock; all state updates on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `RUN` in 1: level; high allows new instructions to start.
- `ADDRESS` in 4: current PC from `register`.
- `OUT_A` in 4: register A from `register`.
- `OUT_B` in 4: register B from `register`.
- `IN_PORT` in 4: external input port.
- `ROM_ADDR` out 4: program ROM address.
- `ROM_DATA` in 8: ROM data, valid 1 cycle after `ROM_ADDR`. Bits [7:4] are the opcode; bits [3:0] are the immediate.
- `LOAD` out 4: one-hot write enables. [0]=A, [1]=B, [2]=OUT, [3]=PC.
- `IN_DATA` out 4: write data accompanying `LOAD`.
- `CARRY` out 1: carry flag.
- `BUSY` out 1: high in any non-IDLE state.
- `DONE` out 1: one-cycle pulse in the PC state.

## Operation
- Contract with `register`: a register changes only in a cycle whose `LOAD` bit is 1, and it captures `IN_DATA` at that clock edge. `register` never self-increments the PC; this block always writes the next PC.
- At most one `LOAD` bit is high in any cycle.
- FSM states: IDLE, FETCH, LATCH, EXEC, PCUPD.
  - IDLE → FETCH when `RUN`=1.
  - FETCH → LATCH → EXEC → PCUPD, unconditionally.
  - PCUPD → FETCH if `RUN`=1, otherwise IDLE.
- FETCH: `ROM_ADDR`=`ADDRESS`.
- LATCH: IR ← `ROM_DATA`.
- EXEC: decode the IR and perform the data write, if any.
  - 0000 ADD A,Im: `LOAD`[0], `IN_DATA`=(A+Im)[3:0].
  - 0101 ADD B,Im: `LOAD`[1], `IN_DATA`=(B+Im)[3:0].
  - 0011 MOV A,Im: `LOAD`[0], Im.
  - 0111 MOV B,Im: `LOAD`[1], Im.
  - 0001 MOV A,B: `LOAD`[0], `OUT_B`.
  - 0100 MOV B,A: `LOAD`[1], `OUT_A`.
  - 0010 IN A: `LOAD`[0], `IN_PORT`.
  - 0110 IN B: `LOAD`[1], `IN_PORT`.
  - 1001 OUT B: `LOAD`[2], `OUT_B`.
  - 1011 OUT Im: `LOAD`[2], Im.
  - 1111 JMP, 1110 JNC: no data write.
  - All other opcodes are NOPs: no write.
- Carry update, at the end of EXEC:
  - ADD instructions: `CARRY` ← bit 4 of the 5-bit unsigned sum.
  - Every other opcode, including jumps and NOPs: `CARRY` ← 0.
- PCUPD: `LOAD`[3]=1, with `IN_DATA` selected as follows.
  - JMP: Im.
  - JNC: Im if the carry flag as it was before this instruction's EXEC is 0, else `ADDRESS`+1. Because EXEC clears carry for JNC, a separate "carry at fetch" copy is held in `c_prev`.
  - Otherwise: `ADDRESS`+1, modulo 16.
  - `DONE`=1.
- PC wrap-around: 15+1 = 0. Continuing from PC 15 to 0 is normal operation, not an error.
- `RUN` falling mid-instruction: the current instruction completes through PCUPD, then the FSM enters IDLE.
- `RST` in any state: next cycle the FSM is in IDLE; IR=0, `CARRY`=0, `c_prev`=0.
  - Any in-flight instruction is abandoned.
  - A write already committed at an earlier edge is not undone.

## Timing
- Reset values: `LOAD`=0000, `IN_DATA`=0, `ROM_ADDR`=0, `CARRY`=0, `BUSY`=0, `DONE`=0.
- Outputs are combinational from the registered state, IR, and current inputs.
  - `LOAD` and `IN_DATA` are 0 outside EXEC and PCUPD.
  - `ROM_ADDR` tracks `ADDRESS` in all states.
- Latency: every instruction takes exactly 4 cycles (FETCH to PCUPD).
  - With `RUN` held high, instructions issue back-to-back: 4 cycles each, with no IDLE cycle between them.
  - From IDLE, the first FETCH is 1 cycle after `RUN` rises.
- Data writes land at the end of EXEC. The PC write lands at the end of PCUPD.
- `OUT_A`/`OUT_B` are sampled in EXEC. They therefore reflect the previous instruction's write.

## Structure
- Shared include `td4_defs.vh` holds:
  - opcode constants;
  - `LOAD` bit indices (LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3);
  - FSM state encodings.
- Sub-module `td4_decode` (combinational) maps opcode to:
  - destination one-hot;
  - source select (imm / A / B / IN_PORT / A+imm / B+imm);
  - PC mode (inc / jmp / jnc).
- The FSM, IR, carry, `c_prev`, and the 5-bit adder live in `td4_sequencer`.

## Test plan
- Reset, then `RUN`=1 with ROM[0]=0x35 (MOV A,5):
  - EXEC cycle: `LOAD`=0001, `IN_DATA`=5.
  - PCUPD cycle: `LOAD`=1000, `IN_DATA`=1, `DONE`=1.
  - Next instruction's FETCH follows 1 cycle later.
- A=0xE, execute 0x03 (ADD A,3):
  - `IN_DATA`=1, `CARRY`=1.
  - A following 0xE8 (JNC 8) gives PC write = `ADDRESS`+1, not 8.
  - A second 0xE8 then jumps to 8, because carry was cleared by the first JNC.
- PC=15 executing 0x70 (MOV B,0): PCUPD `IN_DATA`=0 (wrap); B=0 written in EXEC.
- `IN_PORT`=0xA with 0x20 (IN A), then 0x90 (OUT B) where B=0x6:
  - `LOAD`=0001 with `IN_DATA`=A for the first instruction;
  - `LOAD`=0100 with `IN_DATA`=6 for the second.
  - 0xF3 (JMP 3): no data `LOAD`, PC write 3, `CARRY`=0.
- `RUN` drops during LATCH: the instruction completes through PCUPD, then `BUSY`=0.
- Assert `RST` during EXEC of 0x05 (A=0xF): next cycle `LOAD`=0, `CARRY`=0, state IDLE, no PC write.

Source files
------------

// File: rtl/td4_sequencer_pkg.sv
// TD4 sequencer shared definitions: opcodes, LOAD bit indices, FSM and decode types.
// Pure declarations; no latency and no backpressure.
package td4_sequencer_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam int unsigned LD_A   = 0;
  localparam int unsigned LD_B   = 1;
  localparam int unsigned LD_OUT = 2;
  localparam int unsigned LD_PC  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_PCUPD = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    SRC_NONE, SRC_IMM, SRC_A, SRC_B, SRC_IN, SRC_A_IMM, SRC_B_IMM
  } src_e;

  typedef enum logic [1:0] {PC_INC, PC_JMP, PC_JNC} pc_mode_e;

  typedef struct packed {
    logic [3:0] dst;
    src_e       src;
    pc_mode_e   pc_mode;
  } dec_t;

  function automatic logic [3:0] ld_bit(input int unsigned idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/td4_sequencer_if.sv
// Sequencer-side bundle: ROM port, register-file write port and status.
// Master is the sequencer; slave is the register file / ROM environment.
interface td4_sequencer_if;
  logic       RUN;
  logic [3:0] ADDRESS;
  logic [3:0] OUT_A;
  logic [3:0] OUT_B;
  logic [3:0] IN_PORT;
  logic [3:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic [3:0] LOAD;
  logic [3:0] IN_DATA;
  logic       CARRY;
  logic       BUSY;
  logic       DONE;

  modport master (
    input  RUN, ADDRESS, OUT_A, OUT_B, IN_PORT, ROM_DATA,
    output ROM_ADDR, LOAD, IN_DATA, CARRY, BUSY, DONE
  );

  modport slave (
    output RUN, ADDRESS, OUT_A, OUT_B, IN_PORT, ROM_DATA,
    input  ROM_ADDR, LOAD, IN_DATA, CARRY, BUSY, DONE
  );
endinterface

// File: rtl/td4_decode.sv
// Opcode decoder: destination one-hot, data source and PC update mode.
// Purely combinational, zero latency, no backpressure.
module td4_decode
  import td4_sequencer_pkg::*;
(
  input  logic [3:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o.dst     = 4'b0000;
    dec_o.src     = SRC_NONE;
    dec_o.pc_mode = PC_INC;
    case (op_i)
      OP_ADD_A:  begin dec_o.dst = ld_bit(LD_A);   dec_o.src = SRC_A_IMM; end
      OP_ADD_B:  begin dec_o.dst = ld_bit(LD_B);   dec_o.src = SRC_B_IMM; end
      OP_MOV_A:  begin dec_o.dst = ld_bit(LD_A);   dec_o.src = SRC_IMM;   end
      OP_MOV_B:  begin dec_o.dst = ld_bit(LD_B);   dec_o.src = SRC_IMM;   end
      OP_MOV_AB: begin dec_o.dst = ld_bit(LD_A);   dec_o.src = SRC_B;     end
      OP_MOV_BA: begin dec_o.dst = ld_bit(LD_B);   dec_o.src = SRC_A;     end
      OP_IN_A:   begin dec_o.dst = ld_bit(LD_A);   dec_o.src = SRC_IN;    end
      OP_IN_B:   begin dec_o.dst = ld_bit(LD_B);   dec_o.src = SRC_IN;    end
      OP_OUT_B:  begin dec_o.dst = ld_bit(LD_OUT); dec_o.src = SRC_B;     end
      OP_OUT_IM: begin dec_o.dst = ld_bit(LD_OUT); dec_o.src = SRC_IMM;   end
      OP_JMP:    dec_o.pc_mode = PC_JMP;
      OP_JNC:    dec_o.pc_mode = PC_JNC;
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/latch/exec/pc-update control unit driving the register-file write port.
// Fixed 4 cycles per instruction; RUN gates only the start of the next instruction.
module td4_sequencer
  import td4_sequencer_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  td4_sequencer_if.master   bus
);

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       carry_q, carry_d;
  logic       c_prev_q, c_prev_d;

  dec_t       dec;
  logic [3:0] imm;
  logic [3:0] operand;
  logic [4:0] sum;
  logic       is_add;
  logic       take_jump;

  td4_decode u_decode (
    .op_i  (ir_q[7:4]),
    .dec_o (dec)
  );

  assign imm       = ir_q[3:0];
  assign is_add    = (dec.src == SRC_A_IMM) || (dec.src == SRC_B_IMM);
  assign operand   = (dec.src == SRC_B_IMM) ? bus.OUT_B : bus.OUT_A;
  assign sum       = {1'b0, operand} + {1'b0, imm};
  // JNC looks at the carry captured at fetch, since EXEC has already cleared it
  assign take_jump = (dec.pc_mode == PC_JMP) || ((dec.pc_mode == PC_JNC) && !c_prev_q);

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    carry_d  = carry_q;
    c_prev_d = c_prev_q;
    case (state_q)
      ST_IDLE:  if (bus.RUN) state_d = ST_FETCH;
      ST_FETCH: begin
        c_prev_d = carry_q;
        state_d  = ST_LATCH;
      end
      ST_LATCH: begin
        ir_d    = bus.ROM_DATA;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        carry_d = is_add ? sum[4] : 1'b0;
        state_d = ST_PCUPD;
      end
      ST_PCUPD: state_d = bus.RUN ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      ir_q     <= 8'h00;
      carry_q  <= 1'b0;
      c_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      carry_q  <= carry_d;
      c_prev_q <= c_prev_d;
    end
  end

  always_comb begin
    bus.LOAD    = 4'b0000;
    bus.IN_DATA = 4'h0;
    case (state_q)
      ST_EXEC: begin
        bus.LOAD = dec.dst;
        case (dec.src)
          SRC_IMM:              bus.IN_DATA = imm;
          SRC_A:                bus.IN_DATA = bus.OUT_A;
          SRC_B:                bus.IN_DATA = bus.OUT_B;
          SRC_IN:               bus.IN_DATA = bus.IN_PORT;
          SRC_A_IMM, SRC_B_IMM: bus.IN_DATA = sum[3:0];
          default:              bus.IN_DATA = 4'h0;
        endcase
      end
      ST_PCUPD: begin
        bus.LOAD    = ld_bit(LD_PC);
        bus.IN_DATA = take_jump ? imm : (bus.ADDRESS + 4'd1);
      end
      default: ;
    endcase
  end

  assign bus.ROM_ADDR = bus.ADDRESS;
  assign bus.CARRY    = carry_q;
  assign bus.BUSY     = (state_q != ST_IDLE);
  assign bus.DONE     = (state_q == ST_PCUPD);

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed bench for td4_sequencer with a register-file/ROM model and a write scoreboard.
module tb_td4_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  td4_sequencer_if bus();

  td4_sequencer dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  // Environment: synchronous ROM and the register block the sequencer writes.
  logic [7:0] rom [16];
  logic [7:0] rom_q   = 8'h00;
  logic [3:0] reg_a   = 4'h0;
  logic [3:0] reg_b   = 4'h0;
  logic [3:0] reg_out = 4'h0;
  logic [3:0] reg_pc  = 4'h0;

  assign bus.ADDRESS  = reg_pc;
  assign bus.OUT_A    = reg_a;
  assign bus.OUT_B    = reg_b;
  assign bus.ROM_DATA = rom_q;

  always @(posedge clk) begin
    rom_q <= rom[bus.ROM_ADDR];
    if (bus.LOAD[0]) reg_a   <= bus.IN_DATA;
    if (bus.LOAD[1]) reg_b   <= bus.IN_DATA;
    if (bus.LOAD[2]) reg_out <= bus.IN_DATA;
    if (bus.LOAD[3]) reg_pc  <= bus.IN_DATA;
  end

  typedef struct packed {
    logic [3:0] ld;
    logic [3:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_evt  = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] ld, input logic [3:0] d);
    sb.push_back(exp_t'({ld, d}));
  endtask

  // Advance n cycles; every nonzero LOAD is matched against the next expected write.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.LOAD !== 4'b0000) begin
        n_evt++;
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_load_%0d", n_evt), {bus.LOAD, bus.IN_DATA}, 8'h00);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("load_evt_%0d", n_evt), {bus.LOAD, bus.IN_DATA}, {e.ld, e.d});
        end
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.RUN     = 1'b0;
    bus.IN_PORT = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;

    // MOV A,5 ; MOV A,E ; ADD A,3 ; JNC 8 ; JNC 8 ; .. ; @8 JMP F ; @F MOV B,0
    rom[0]  = 8'h35; rom[1] = 8'h3E; rom[2] = 8'h03; rom[3] = 8'hE8;
    rom[4]  = 8'hE8; rom[8] = 8'hFF; rom[15] = 8'h70;
    push(4'b0001, 4'h5); push(4'b1000, 4'h1);
    push(4'b0001, 4'hE); push(4'b1000, 4'h2);
    push(4'b0001, 4'h1); push(4'b1000, 4'h3);
    push(4'b1000, 4'h4);
    push(4'b1000, 4'h8);
    push(4'b1000, 4'hF);
    push(4'b0010, 4'h0); push(4'b1000, 4'h0);

    cyc(2);
    chk("rst_load",     {4'h0, bus.LOAD},     8'h00);
    chk("rst_in_data",  {4'h0, bus.IN_DATA},  8'h00);
    chk("rst_rom_addr", {4'h0, bus.ROM_ADDR}, 8'h00);
    chk("rst_carry",    {7'h0, bus.CARRY},    8'h00);
    chk("rst_busy",     {7'h0, bus.BUSY},     8'h00);
    chk("rst_done",     {7'h0, bus.DONE},     8'h00);

    rst = 1'b0;
    cyc(1);
    bus.RUN = 1'b1;
    cyc(1);
    chk("fetch0_busy",     {7'h0, bus.BUSY},     8'h01);
    chk("fetch0_rom_addr", {4'h0, bus.ROM_ADDR}, 8'h00);
    cyc(3);
    chk("pcupd0_done",     {7'h0, bus.DONE},     8'h01);
    cyc(1);
    chk("fetch1_done",     {7'h0, bus.DONE},     8'h00);
    chk("fetch1_busy",     {7'h0, bus.BUSY},     8'h01);
    chk("fetch1_rom_addr", {4'h0, bus.ROM_ADDR}, 8'h01);
    cyc(7);
    chk("add_carry_set",   {7'h0, bus.CARRY},    8'h01);
    cyc(4);
    chk("jnc_carry_clr",   {7'h0, bus.CARRY},    8'h00);
    cyc(8);
    cyc(1);
    chk("fetch15_rom_addr", {4'h0, bus.ROM_ADDR}, 8'h0F);
    cyc(1);
    bus.RUN = 1'b0;
    cyc(2);
    chk("run_drop_done",   {7'h0, bus.DONE},     8'h01);
    cyc(1);
    chk("run_drop_idle",   {7'h0, bus.BUSY},     8'h00);
    chk("wrap_pc",         {4'h0, reg_pc},       8'h00);
    chk("mov_b0_written",  {4'h0, reg_b},        8'h00);
    chk("add_a_result",    {4'h0, reg_a},        8'h01);
    cyc(3);
    chk("stay_idle",       {7'h0, bus.BUSY},     8'h00);
    chk("sb_empty_1",      8'(sb.size()),        8'h00);

    // MOV B,6 ; IN A ; OUT B ; ADD B,A(imm) ; JMP 3
    rom[0] = 8'h76; rom[1] = 8'h20; rom[2] = 8'h90; rom[3] = 8'h5A; rom[4] = 8'hF3;
    bus.IN_PORT = 4'hA;
    push(4'b0010, 4'h6); push(4'b1000, 4'h1);
    push(4'b0001, 4'hA); push(4'b1000, 4'h2);
    push(4'b0100, 4'h6); push(4'b1000, 4'h3);
    push(4'b0010, 4'h0); push(4'b1000, 4'h4);
    push(4'b1000, 4'h3);
    bus.RUN = 1'b1;
    cyc(1);
    cyc(15);
    chk("add_b_carry",     {7'h0, bus.CARRY},    8'h01);
    cyc(1);
    bus.RUN = 1'b0;
    cyc(3);
    chk("jmp_carry_clr",   {7'h0, bus.CARRY},    8'h00);
    chk("jmp_done",        {7'h0, bus.DONE},     8'h01);
    cyc(1);
    chk("t4_idle",         {7'h0, bus.BUSY},     8'h00);
    chk("out_reg",         {4'h0, reg_out},      8'h06);
    chk("in_a_reg",        {4'h0, reg_a},        8'h0A);
    chk("jmp_pc",          {4'h0, reg_pc},       8'h03);
    chk("sb_empty_2",      8'(sb.size()),        8'h00);

    // @3 MOV B,F ; MOV A,B ; OUT 7 ; NOP ; ADD A,5 (reset in EXEC)
    rom[3] = 8'h7F; rom[4] = 8'h10; rom[5] = 8'hB7; rom[6] = 8'h80; rom[7] = 8'h05;
    push(4'b0010, 4'hF); push(4'b1000, 4'h4);
    push(4'b0001, 4'hF); push(4'b1000, 4'h5);
    push(4'b0100, 4'h7); push(4'b1000, 4'h6);
    push(4'b1000, 4'h7);
    push(4'b0001, 4'h4);
    bus.RUN = 1'b1;
    cyc(1);
    cyc(18);
    chk("pre_rst_carry",   {7'h0, bus.CARRY},    8'h00);
    rst     = 1'b1;
    bus.RUN = 1'b0;
    cyc(1);
    chk("mid_rst_load",    {4'h0, bus.LOAD},     8'h00);
    chk("mid_rst_carry",   {7'h0, bus.CARRY},    8'h00);
    chk("mid_rst_busy",    {7'h0, bus.BUSY},     8'h00);
    chk("mid_rst_done",    {7'h0, bus.DONE},     8'h00);
    chk("committed_a",     {4'h0, reg_a},        8'h04);
    rst = 1'b0;
    cyc(2);
    chk("no_pc_write",     {4'h0, reg_pc},       8'h07);
    chk("post_rst_idle",   {7'h0, bus.BUSY},     8'h00);
    chk("out_im_reg",      {4'h0, reg_out},      8'h07);
    chk("sb_empty_3",      8'(sb.size()),        8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
